// File: rtl/rbcp_reg_bank_pkg.sv
// RBCP slave register map shared by the user-side register banks.
// Offsets are relative to each slave's base-address window.
package rbcp_reg_bank_pkg;

  localparam logic [7:0] OFS_ID    = 8'h00;
  localparam logic [7:0] OFS_DIP   = 8'h01;
  localparam logic [7:0] OFS_EVT   = 8'h02;
  localparam logic [7:0] OFS_PULSE = 8'h03;
  localparam logic [7:0] OFS_USER0 = 8'h04;

  localparam int ACK_LAT = 1;

endpackage

// File: rtl/rbcp_reg_bank_if.sv
// RBCP bus seen by one slave: strobes, address and data from SiTCP,
// read data and acknowledge back from the slave.
interface rbcp_reg_bank_if;

  logic        RBCP_WE;
  logic        RBCP_RE;
  logic [31:0] RBCP_ADDR;
  logic [7:0]  RBCP_WD;
  logic [7:0]  RBCP_RD;
  logic        RBCP_ACK;

  modport master (
    output RBCP_WE, RBCP_RE, RBCP_ADDR, RBCP_WD,
    input  RBCP_RD, RBCP_ACK
  );

  modport slave (
    input  RBCP_WE, RBCP_RE, RBCP_ADDR, RBCP_WD,
    output RBCP_RD, RBCP_ACK
  );

endinterface

// File: rtl/rbcp_reg_bank_sync_2ff.sv
// Two-flop synchroniser for slow asynchronous inputs such as DIP switches.
// Reset clears both stages.
module rbcp_reg_bank_sync_2ff #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/rbcp_reg_bank.sv
// Parametrised RBCP slave register bank: ID/DIP read-only map, sticky
// W1C events, write-strobe pulse register and RW user registers.
module rbcp_reg_bank
  import rbcp_reg_bank_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_REGS  = 16,
  parameter logic [7:0]  ID_CODE   = 8'h5A,
  parameter int          DIP_W     = 3,
  parameter int          NUM_EVT   = 8
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  rbcp_reg_bank_if.slave        bus,
  input  logic [DIP_W-1:0]      DIP,
  input  logic [NUM_EVT-1:0]    EVENT_IN,
  output logic [7:0]            PULSE_OUT,
  output logic [NUM_REGS*8-1:0] REG_OUT
);

  localparam int AW = $clog2(NUM_REGS);

  logic [DIP_W-1:0]   dip_s;
  logic               hit;
  logic               wr;
  logic               rd;
  logic [AW-1:0]      ofs;
  logic [7:0]         ofs8;
  logic               is_id;
  logic               is_dip;
  logic               is_evt;
  logic               is_pls;
  logic               is_usr;
  logic [NUM_EVT-1:0] evt_q;
  logic [NUM_EVT-1:0] evt_clr;
  logic [7:0]         regs_q [NUM_REGS];
  logic [7:0]         rd_mux;

  rbcp_reg_bank_sync_2ff #(.W(DIP_W)) u_dip_sync (
    .CLK  (CLK),
    .RSTn (RSTn),
    .d    (DIP),
    .q    (dip_s)
  );

  assign hit = (bus.RBCP_WE | bus.RBCP_RE)
             & (bus.RBCP_ADDR[31:AW] == BASE_ADDR[31:AW]);
  assign ofs  = bus.RBCP_ADDR[AW-1:0];
  assign ofs8 = 8'(ofs);

  // A simultaneous WE+RE is a write, so the read path stays quiet.
  assign wr = hit & bus.RBCP_WE;
  assign rd = hit & bus.RBCP_RE & ~bus.RBCP_WE;

  assign is_id  = (ofs8 == OFS_ID);
  assign is_dip = (ofs8 == OFS_DIP);
  assign is_evt = (ofs8 == OFS_EVT);
  assign is_pls = (ofs8 == OFS_PULSE);
  assign is_usr = (ofs8 >= OFS_USER0);

  assign evt_clr = (wr && is_evt) ? bus.RBCP_WD[NUM_EVT-1:0] : '0;

  // New events are OR-ed in after the clear so a same-cycle set survives.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      evt_q <= '0;
    end else begin
      evt_q <= (evt_q & ~evt_clr) | EVENT_IN;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr && is_usr) begin
      regs_q[ofs] <= bus.RBCP_WD;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      is_id:   rd_mux = ID_CODE;
      is_dip:  rd_mux = 8'(dip_s);
      is_evt:  rd_mux = 8'(evt_q);
      is_pls:  rd_mux = '0;
      default: rd_mux = regs_q[ofs];
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      bus.RBCP_ACK <= 1'b0;
      bus.RBCP_RD  <= '0;
      PULSE_OUT    <= '0;
    end else begin
      bus.RBCP_ACK <= hit;
      bus.RBCP_RD  <= rd ? rd_mux : '0;
      PULSE_OUT    <= (wr && is_pls) ? bus.RBCP_WD : '0;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
    if (k >= int'(OFS_USER0)) begin : g_rw
      assign REG_OUT[k*8 +: 8] = regs_q[k];
    end else begin : g_ro
      assign REG_OUT[k*8 +: 8] = '0;
    end
  end

endmodule

// File: tb/tb_rbcp_reg_bank.sv
// Self-checking bench for rbcp_reg_bank: directed map checks plus random
// bus traffic compared against a behavioural register-map model.
module tb_rbcp_reg_bank;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          NREG = 16;

  logic         clk;
  logic         rst_n;
  logic [2:0]   dip;
  logic [7:0]   evt_in;
  logic [7:0]   pulse_out;
  logic [127:0] reg_out;

  rbcp_reg_bank_if bus ();

  rbcp_reg_bank #(
    .BASE_ADDR (BASE),
    .NUM_REGS  (NREG),
    .ID_CODE   (8'h5A),
    .DIP_W     (3),
    .NUM_EVT   (8)
  ) dut (
    .CLK       (clk),
    .RSTn      (rst_n),
    .bus       (bus),
    .DIP       (dip),
    .EVENT_IN  (evt_in),
    .PULSE_OUT (pulse_out),
    .REG_OUT   (reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [7:0] mdl_regs [NREG];
  logic [7:0] mdl_evt;
  logic [2:0] dip_d1;
  logic [2:0] dip_d2;

  logic       last_ack;
  logic [7:0] last_rd;
  logic [7:0] last_pulse;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < NREG; i++) mdl_regs[i] = '0;
    mdl_evt = '0;
    dip_d1  = '0;
    dip_d2  = '0;
  endtask

  task automatic bus_idle();
    bus.RBCP_WE   = 1'b0;
    bus.RBCP_RE   = 1'b0;
    bus.RBCP_ADDR = '0;
    bus.RBCP_WD   = '0;
    evt_in        = '0;
  endtask

  // One bus cycle: drive at negedge, predict, check just after posedge.
  task automatic tick(input logic we, input logic re,
                      input logic [31:0] addr, input logic [7:0] wd,
                      input logic [7:0] ev);
    logic         hit;
    logic [3:0]   off;
    logic [7:0]   erd;
    logic [7:0]   epl;
    logic [7:0]   clr;
    logic [7:0]   dvis;
    logic [127:0] ero;
    @(negedge clk);
    bus.RBCP_WE   = we;
    bus.RBCP_RE   = re;
    bus.RBCP_ADDR = addr;
    bus.RBCP_WD   = wd;
    evt_in        = ev;
    hit  = (we | re) && (addr[31:4] == BASE[31:4]);
    off  = addr[3:0];
    dvis = {5'b0, dip_d2};
    dip_d2 = dip_d1;
    dip_d1 = dip;
    erd = '0;
    if (hit && re && !we) begin
      case (off)
        4'd0:    erd = 8'h5A;
        4'd1:    erd = dvis;
        4'd2:    erd = mdl_evt;
        4'd3:    erd = 8'h00;
        default: erd = mdl_regs[off];
      endcase
    end
    epl = (hit && we && off == 4'd3) ? wd : 8'h00;
    clr = (hit && we && off == 4'd2) ? wd : 8'h00;
    if (hit && we && off >= 4'd4) mdl_regs[off] = wd;
    mdl_evt = (mdl_evt & ~clr) | ev;
    ero = '0;
    for (int k = 4; k < NREG; k++) ero[k*8 +: 8] = mdl_regs[k];
    @(posedge clk);
    #1;
    last_ack   = bus.RBCP_ACK;
    last_rd    = bus.RBCP_RD;
    last_pulse = pulse_out;
    chk("ack", 128'(last_ack), 128'(hit));
    chk("rd", 128'(last_rd), 128'(erd));
    chk("pulse", 128'(last_pulse), 128'(epl));
    chk("reg_out", reg_out, ero);
    bus_idle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 128'(bus.RBCP_ACK), 128'(0));
    chk({tag, "_rd"}, 128'(bus.RBCP_RD), 128'(0));
    chk({tag, "_pulse"}, 128'(pulse_out), 128'(0));
    chk({tag, "_reg_out"}, reg_out, 128'(0));
  endtask

  initial begin
    logic [31:0] a;
    logic        we;
    logic        re;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    dip    = '0;
    bus_idle();
    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    tick(1, 0, 32'h104, 8'hA5, 8'h00);
    chk("w104_reg", 128'(reg_out[39:32]), 128'(8'hA5));
    tick(0, 1, 32'h104, 8'h00, 8'h00);
    chk("r104", 128'(last_rd), 128'(8'hA5));

    tick(0, 1, 32'h100, 8'h00, 8'h00);
    chk("r_id", 128'(last_rd), 128'(8'h5A));
    dip = 3'b101;
    repeat (3) tick(0, 0, 32'h0, 8'h00, 8'h00);
    tick(0, 1, 32'h101, 8'h00, 8'h00);
    chk("r_dip", 128'(last_rd), 128'(8'h05));
    tick(1, 0, 32'h100, 8'hFF, 8'h00);
    chk("w_id_ack", 128'(last_ack), 128'(1));
    tick(0, 1, 32'h100, 8'h00, 8'h00);
    chk("r_id_after_w", 128'(last_rd), 128'(8'h5A));

    tick(0, 0, 32'h0, 8'h00, 8'h04);
    tick(0, 1, 32'h102, 8'h00, 8'h00);
    chk("r_evt_set", 128'(last_rd), 128'(8'h04));
    tick(1, 0, 32'h102, 8'h04, 8'h00);
    tick(0, 1, 32'h102, 8'h00, 8'h00);
    chk("r_evt_clr", 128'(last_rd), 128'(8'h00));
    tick(1, 0, 32'h102, 8'h02, 8'h02);
    tick(0, 1, 32'h102, 8'h00, 8'h00);
    chk("r_evt_setwin", 128'(last_rd), 128'(8'h02));

    tick(1, 0, 32'h103, 8'h81, 8'h00);
    chk("pulse_81", 128'(last_pulse), 128'(8'h81));
    tick(0, 0, 32'h0, 8'h00, 8'h00);
    chk("pulse_gone", 128'(last_pulse), 128'(8'h00));
    tick(1, 0, 32'h103, 8'h01, 8'h00);
    chk("pulse_b2b_1", 128'(last_pulse), 128'(8'h01));
    tick(1, 0, 32'h103, 8'h02, 8'h00);
    chk("pulse_b2b_2", 128'(last_pulse), 128'(8'h02));

    tick(1, 0, 32'h110, 8'h99, 8'h00);
    chk("miss_ack", 128'(last_ack), 128'(0));
    tick(1, 1, 32'h105, 8'h3C, 8'h00);
    chk("wr_rd_ack", 128'(last_ack), 128'(1));
    chk("wr_rd_rd", 128'(last_rd), 128'(0));
    chk("wr_rd_reg", 128'(reg_out[47:40]), 128'(8'h3C));

    // Reset lands while a write's ACK is pending.
    @(negedge clk);
    bus.RBCP_WE   = 1'b1;
    bus.RBCP_ADDR = 32'h103;
    bus.RBCP_WD   = 8'h77;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    bus_idle();
    mdl_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 0, 32'h0, 8'h00, 8'h00);
    chk("rst_no_ack", 128'(last_ack), 128'(0));

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) dip = 3'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(32'hE0, 32'h13F))
                                       : 32'h100 + 32'($urandom_range(0, 15));
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 1) == 0);
      tick(we, re, a, 8'($urandom),
           ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
    end
    repeat (2) tick(0, 0, 32'h0, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
